// File: rtl/addr_trans_ctrl_if.sv
// Address-translation bundle shared by the mode controller and the L1/TLB/walker side.
interface address_translation_if;
  logic sv32;
  logic sv39;
  logic sv48;
  logic sv57;
  logic sv64;
  logic addr_trans_on;

  modport walker (output sv32, sv39, sv48, sv57, sv64, addr_trans_on);
  modport client (input  sv32, sv39, sv48, sv57, sv64, addr_trans_on);
endinterface

// File: rtl/addr_trans_ctrl.sv
// Translation-mode controller: serialises satp MODE writes and SFENCE.VMA through a TLB flush.
// Optional flush watchdog enabled by defining ADDR_TRANS_FLUSH_TIMEOUT_EN.
module addr_trans_ctrl #(
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       satp_wr_req,
  input  logic       satp_mode_wdata,
  output logic       satp_wr_ack,
  input  logic       sfence_req,
  output logic       sfence_ack,
  input  logic [1:0] priv_level,
  input  logic       mprv,
  input  logic [1:0] mpp,
  output logic       tlb_flush_req,
  input  logic       tlb_flush_done,
  output logic       busy,
  output logic       flush_timeout,
  output logic       fetch_trans_on,
  address_translation_if.walker at_if
);

  localparam int unsigned PRIV_W = 2;
  localparam logic [PRIV_W-1:0] PRIV_M = PRIV_W'(3);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  state_t            state_q;
  logic              mode_q;
  logic              pend_q;
  logic [1:0]        src_q;
  logic [PRIV_W-1:0] dpriv_c;
  logic              mode_next_c;
  logic              expire_c;

  // Data accesses may run at MPP privilege under MPRV; fetch always uses the current level.
  always_comb begin
    dpriv_c     = mprv ? mpp : priv_level;
    mode_next_c = (state_q == ST_APPLY) ? pend_q : mode_q;
  end

`ifdef ADDR_TRANS_FLUSH_TIMEOUT_EN
  localparam int unsigned CNT_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Watchdog fires on the last allowed FLUSH cycle unless the TLBs answer in that same cycle.
  assign expire_c = (state_q == ST_FLUSH) && !tlb_flush_done &&
                    (cnt_q == CNT_W'(FLUSH_TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q         <= '0;
      flush_timeout <= 1'b0;
    end else begin
      if (state_q == ST_RUN) begin
        cnt_q <= '0;
      end else if (state_q == ST_FLUSH) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (expire_c) begin
        flush_timeout <= 1'b1;
      end
    end
  end
`else
  // Without the watchdog FLUSH waits for the TLBs forever; the limit is only sanity-checked.
  if (FLUSH_TIMEOUT == 0) begin : g_timeout_param_unused
  end

  assign expire_c = 1'b0;

  always_ff @(posedge CLK) begin
    flush_timeout <= 1'b0;
  end
`endif

  // Main FSM; acks, flush request and busy are set on the edge entering the state they belong to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q             <= ST_RUN;
      mode_q              <= 1'b0;
      pend_q              <= 1'b0;
      src_q               <= 2'b00;
      satp_wr_ack         <= 1'b0;
      sfence_ack          <= 1'b0;
      tlb_flush_req       <= 1'b0;
      busy                <= 1'b0;
      fetch_trans_on      <= 1'b0;
      at_if.sv32          <= 1'b0;
      at_if.addr_trans_on <= 1'b0;
    end else begin
      satp_wr_ack <= 1'b0;
      sfence_ack  <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (satp_wr_req || sfence_req) begin
            state_q       <= ST_FLUSH;
            pend_q        <= satp_wr_req ? satp_mode_wdata : mode_q;
            src_q         <= {satp_wr_req, sfence_req};
            tlb_flush_req <= 1'b1;
            busy          <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (tlb_flush_done || expire_c) begin
            state_q       <= ST_APPLY;
            tlb_flush_req <= 1'b0;
            satp_wr_ack   <= src_q[1];
            sfence_ack    <= src_q[0];
          end
        end
        ST_APPLY: begin
          state_q <= ST_RUN;
          mode_q  <= pend_q;
          busy    <= 1'b0;
        end
        default: begin
          state_q       <= ST_RUN;
          tlb_flush_req <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
      at_if.sv32          <= mode_next_c;
      at_if.addr_trans_on <= mode_next_c && (dpriv_c != PRIV_M);
      fetch_trans_on      <= mode_next_c && (priv_level != PRIV_M);
    end
  end

  // RV32 only: the wider Sv modes never become active.
  always_ff @(posedge CLK) begin
    at_if.sv39 <= 1'b0;
    at_if.sv48 <= 1'b0;
    at_if.sv57 <= 1'b0;
    at_if.sv64 <= 1'b0;
  end

endmodule

// File: tb/tb_addr_trans_ctrl.sv
// Self-checking bench for addr_trans_ctrl; expectations come from a transaction-level mode model.
module tb_addr_trans_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       satp_wr_req, satp_mode_wdata, sfence_req;
  logic       satp_wr_ack, sfence_ack;
  logic [1:0] priv_level, mpp;
  logic       mprv;
  logic       tlb_flush_req, tlb_flush_done;
  logic       busy, flush_timeout, fetch_trans_on;

  always #5 CLK = ~CLK;

  address_translation_if at_if ();

  addr_trans_ctrl #(.FLUSH_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .satp_wr_req(satp_wr_req), .satp_mode_wdata(satp_mode_wdata), .satp_wr_ack(satp_wr_ack),
    .sfence_req(sfence_req), .sfence_ack(sfence_ack),
    .priv_level(priv_level), .mprv(mprv), .mpp(mpp),
    .tlb_flush_req(tlb_flush_req), .tlb_flush_done(tlb_flush_done),
    .busy(busy), .flush_timeout(flush_timeout), .fetch_trans_on(fetch_trans_on),
    .at_if(at_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: active mode, sticky timeout, and the privilege inputs seen at the last edge.
  logic       model_mode;
  logic       model_to;
  logic [1:0] p_priv, p_mpp;
  logic       p_mprv;

  logic [7:0] obs;
  assign obs = {tlb_flush_req, busy, satp_wr_ack, sfence_ack, flush_timeout,
                at_if.sv32, at_if.addr_trans_on, fetch_trans_on};

  function automatic logic [7:0] expv(input logic fr, input logic bz, input logic sa,
                                      input logic fa, input logic m);
    logic [1:0] dp;
    dp = p_mprv ? p_mpp : p_priv;
    return {fr, bz, sa, fa, model_to, m, m && (dp != 2'd3), m && (p_priv != 2'd3)};
  endfunction

  task automatic tick();
    p_priv = priv_level;
    p_mprv = mprv;
    p_mpp  = mpp;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] wide;
    RST = 1'b1; satp_wr_req = 1'b1; satp_mode_wdata = 1'b1; sfence_req = 1'b1;
    priv_level = 2'd1; mprv = 1'b0; mpp = 2'd0; tlb_flush_done = 1'b1;
    tick(); tick();
    model_mode = 1'b0; model_to = 1'b0;
    if (obs !== 8'h00) begin n_err++; $display("FAIL reset_outputs: got %b want %b", obs, 8'h00); end
    n_cmp++;
    wide = {at_if.sv39, at_if.sv48, at_if.sv57, at_if.sv64};
    if (wide !== 4'b0) begin n_err++; $display("FAIL reset_wide_modes: got %b want 0000", wide); end
    n_cmp++;
    satp_wr_req = 1'b0; sfence_req = 1'b0; tlb_flush_done = 1'b0;
    RST = 1'b0;
    tick();
    if (obs !== expv(0, 0, 0, 0, 0)) begin n_err++; $display("FAIL reset_idle: got %b want %b", obs, expv(0, 0, 0, 0, 0)); end
    n_cmp++;
  endtask

  task automatic test_bare_to_sv32();
    logic [7:0] e;
    priv_level = 2'd1; mprv = 1'b0;
    satp_wr_req = 1'b1; satp_mode_wdata = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 3)      e = expv(1, 1, 0, 0, model_mode);
      else if (c == 4) e = expv(0, 1, 1, 0, model_mode);
      else             e = expv(0, 0, 0, 0, model_mode);
      if (obs !== e) begin n_err++; $display("FAIL bare_to_sv32 c%0d: got %b want %b", c, obs, e); end
      n_cmp++;
      tlb_flush_done = (c == 3);
      if (c == 4) begin satp_wr_req = 1'b0; model_mode = 1'b1; end
    end
  endtask

  task automatic test_priv_gating();
    logic [1:0] pv [5] = '{2'd3, 2'd3, 2'd3, 2'd2, 2'd1};
    logic       mv [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] mp [5] = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      priv_level = pv[i]; mprv = mv[i]; mpp = mp[i];
      tick();
      if (obs !== expv(0, 0, 0, 0, model_mode)) begin
        n_err++; $display("FAIL priv_gating step%0d: got %b want %b", i, obs, expv(0, 0, 0, 0, model_mode));
      end
      n_cmp++;
    end
  endtask

  task automatic test_sfence_only();
    logic [7:0] e;
    tlb_flush_done = 1'b1;
    tick();
    tlb_flush_done = 1'b0;
    if (obs !== expv(0, 0, 0, 0, model_mode)) begin n_err++; $display("FAIL stray_done: got %b want %b", obs, expv(0, 0, 0, 0, model_mode)); end
    n_cmp++;
    sfence_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c <= 2)      e = expv(1, 1, 0, 0, model_mode);
      else if (c == 3) e = expv(0, 1, 0, 1, model_mode);
      else             e = expv(0, 0, 0, 0, model_mode);
      if (obs !== e) begin n_err++; $display("FAIL sfence_only c%0d: got %b want %b", c, obs, e); end
      n_cmp++;
      tlb_flush_done = (c == 2);
      if (c == 3) sfence_req = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] e;
    satp_wr_req = 1'b1; satp_mode_wdata = 1'b0; sfence_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1)      e = expv(1, 1, 0, 0, model_mode);
      else if (c == 2) e = expv(0, 1, 1, 1, model_mode);
      else             e = expv(0, 0, 0, 0, model_mode);
      if (obs !== e) begin n_err++; $display("FAIL simultaneous c%0d: got %b want %b", c, obs, e); end
      n_cmp++;
      tlb_flush_done = (c == 1);
      if (c == 2) begin satp_wr_req = 1'b0; sfence_req = 1'b0; model_mode = 1'b0; end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    satp_wr_req = 1'b1; satp_mode_wdata = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      case (c)
        1, 4:    e = expv(1, 1, 0, 0, model_mode);
        2, 5:    e = expv(0, 1, 1, 0, model_mode);
        default: e = expv(0, 0, 0, 0, model_mode);
      endcase
      if (obs !== e) begin n_err++; $display("FAIL back_to_back c%0d: got %b want %b", c, obs, e); end
      n_cmp++;
      tlb_flush_done = (c == 1) || (c == 4);
      if (c == 2) model_mode = 1'b1;
      if (c == 4) satp_wr_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [7:0] e;
    sfence_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      e = (c <= 2) ? expv(1, 1, 0, 0, model_mode) : expv(0, 0, 0, 0, model_mode);
      if (obs !== e) begin n_err++; $display("FAIL reset_mid_flush c%0d: got %b want %b", c, obs, e); end
      n_cmp++;
      if (c == 2) begin RST = 1'b1; model_mode = 1'b0; model_to = 1'b0; end
      if (c == 3) begin RST = 1'b0; sfence_req = 1'b0; end
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    logic [1:0] sel;
    logic       wd;
    int         d, idle;
    for (int t = 0; t < 30; t++) begin
      sel = 2'($urandom_range(1, 3));
      wd  = 1'($urandom);
      d   = $urandom_range(1, 3);
      satp_wr_req = sel[1]; sfence_req = sel[0]; satp_mode_wdata = wd;
      priv_level = 2'($urandom); mprv = 1'($urandom); mpp = 2'($urandom);
      for (int c = 1; c <= d + 2; c++) begin
        tick();
        if (c <= d)          e = expv(1, 1, 0, 0, model_mode);
        else if (c == d + 1) e = expv(0, 1, sel[1], sel[0], model_mode);
        else                 e = expv(0, 0, 0, 0, model_mode);
        if (obs !== e) begin n_err++; $display("FAIL random t%0d c%0d: got %b want %b", t, c, obs, e); end
        n_cmp++;
        tlb_flush_done = (c == d);
        priv_level = 2'($urandom); mprv = 1'($urandom); mpp = 2'($urandom);
        if (c == d + 1) begin
          satp_wr_req = 1'b0; sfence_req = 1'b0;
          if (sel[1]) model_mode = wd;
        end
      end
      idle = $urandom_range(1, 3);
      for (int i = 0; i < idle; i++) begin
        tlb_flush_done = 1'($urandom);
        tick();
        if (obs !== expv(0, 0, 0, 0, model_mode)) begin
          n_err++; $display("FAIL random_idle t%0d: got %b want %b", t, obs, expv(0, 0, 0, 0, model_mode));
        end
        n_cmp++;
        priv_level = 2'($urandom); mprv = 1'($urandom); mpp = 2'($urandom);
      end
      tlb_flush_done = 1'b0;
    end
  endtask

`ifdef ADDR_TRANS_FLUSH_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] e;
    logic       wd;
    wd = ~model_mode;
    priv_level = 2'd0; mprv = 1'b0; tlb_flush_done = 1'b0;
    satp_wr_req = 1'b1; satp_mode_wdata = wd;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c <= 4)      e = expv(1, 1, 0, 0, model_mode);
      else if (c == 5) e = expv(0, 1, 1, 0, model_mode);
      else             e = expv(0, 0, 0, 0, model_mode);
      if (obs !== e) begin n_err++; $display("FAIL timeout c%0d: got %b want %b", c, obs, e); end
      n_cmp++;
      if (c == 4) model_to = 1'b1;
      if (c == 5) begin satp_wr_req = 1'b0; model_mode = wd; end
    end
  endtask
`else
  task automatic test_timeout();
    logic [7:0] e;
    priv_level = 2'd0; mprv = 1'b0; tlb_flush_done = 1'b0;
    sfence_req = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c <= 20)      e = expv(1, 1, 0, 0, model_mode);
      else if (c == 21) e = expv(0, 1, 0, 1, model_mode);
      else              e = expv(0, 0, 0, 0, model_mode);
      if (obs !== e) begin n_err++; $display("FAIL no_timeout c%0d: got %b want %b", c, obs, e); end
      n_cmp++;
      tlb_flush_done = (c == 20);
      if (c == 21) sfence_req = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bare_to_sv32();
    test_priv_gating();
    test_sfence_only();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_flush();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addr_trans_ctrl.md
# addr_trans_ctrl

Translation-mode controller that owns the driving end of the address-translation bundle. It holds the active satp translation mode and evaluates the effective privilege level. From these it drives `sv32`..`sv64` and `addr_trans_on` to the L1 caches, TLBs and page walker. Every satp MODE write and every SFENCE.VMA passes through a TLB flush handshake before the new mode becomes visible. The block sits between the CSR/privilege unit and the memory-side translation hardware.

## Interface
Parameters:
- `FLUSH_TIMEOUT`, 64: watchdog limit in cycles. Only used when `ADDR_TRANS_FLUSH_TIMEOUT_EN` is defined.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `CLK` in 1: clock.
- `RST` in 1: synchronous, active-high reset.
- `satp_wr_req` in 1: satp write request. Held high until `satp_wr_ack`.
- `satp_mode_wdata` in 1: satp.MODE bit 31 being written. 1 = Sv32, 0 = Bare.
- `satp_wr_ack` out 1: one-cycle completion pulse for a satp write.
- `sfence_req` in 1: SFENCE.VMA request. Held high until `sfence_ack`.
- `sfence_ack` out 1: one-cycle completion pulse for an SFENCE.VMA.
- `priv_level` in 2: current privilege. 0 = U, 1 = S, 3 = M.
- `mprv` in 1: mstatus.MPRV.
- `mpp` in 2: mstatus.MPP.
- `tlb_flush_req` out 1: level flush request to all TLBs.
- `tlb_flush_done` in 1: flush-complete pulse from the TLBs, OR-combined.
- `busy` out 1: high whenever the state is not RUN.
- `flush_timeout` out 1: sticky watchdog flag. Tied 0 when the macro is absent.
- `fetch_trans_on` out 1: translation enable for instruction fetch.
- `at_if` `address_translation_if.walker`: drives `sv32`, `sv39`, `sv48`, `sv57`, `sv64`, `addr_trans_on`.

## Operation
- State machine: RUN, FLUSH, APPLY. Reset enters RUN.
- `mode_q` (1 bit) is the active mode. It resets to 0 (Bare).
- `pend_q` is the pending mode. `src_q` (2 bits: satp, sfence) records which requests are being served.
- RUN:
  - `satp_wr_req` or `sfence_req` → FLUSH.
  - On that entry, `pend_q` ← `satp_mode_wdata` if `satp_wr_req`, else `mode_q`.
  - `src_q` records both request bits.
  - If both requests arrive together, one flush serves both, and the mode comes from satp.
- FLUSH:
  - `tlb_flush_req` = 1.
  - Stay until `tlb_flush_done` = 1, then → APPLY.
  - Request inputs are ignored here. New requests are not sampled; a requester simply holds its request until the ack.
- APPLY (one cycle):
  - `mode_q` ← `pend_q`.
  - Pulse `satp_wr_ack` and/or `sfence_ack` per `src_q`.
  - → RUN.
  - A request still high in the following RUN cycle is treated as a new request. Requesters must drop the request in the cycle after its ack.
- Effective data privilege `dpriv` = `mpp` if `mprv` = 1, else `priv_level`. Fetch privilege = `priv_level`.
- Registered outputs, evaluated every cycle in any state from the next value of `mode_q`:
  - `sv32` = `mode_q`.
  - `addr_trans_on` = `mode_q` && `dpriv` != 3.
  - `fetch_trans_on` = `mode_q` && `priv_level` != 3.
- `sv39`, `sv48`, `sv57`, `sv64` are constant 0 (RV32 only).
- Reserved privilege value 2 is treated as not-M, i.e. translation follows `mode_q`.
- `RST` in any state:
  - State → RUN, `mode_q` = 0.
  - All outputs 0, including the `at_if` signals, both acks, `tlb_flush_req`, `busy` and `flush_timeout`.
  - An in-progress flush is abandoned without an ack.

## Timing
- Request sampled high in cycle 0 → FLUSH in cycle 1; `tlb_flush_req` and `busy` high from cycle 1.
- `tlb_flush_done` in cycle k (k ≥ 1) → APPLY in cycle k+1; ack high in k+1.
- New `sv32` / `addr_trans_on` visible in cycle k+2. Back in RUN in cycle k+2.
- `tlb_flush_done` already high in cycle 1 → minimum request-to-ack latency of 2 cycles.
- Privilege, `mprv` or `mpp` change in cycle t → outputs updated in cycle t+1. This also applies during FLUSH, using the old `mode_q`.
- `tlb_flush_done` outside FLUSH is ignored.

## Configuration
- `ADDR_TRANS_FLUSH_TIMEOUT_EN` defined:
  - A counter clears on entry to FLUSH and increments each FLUSH cycle.
  - If it reaches `FLUSH_TIMEOUT` without `tlb_flush_done`, the block → APPLY as if done and sets `flush_timeout`.
  - `flush_timeout` stays set until `RST`.
- Macro absent:
  - No counter is built; FLUSH waits indefinitely.
  - `flush_timeout` is tied 0.

## Test plan
- Bare → Sv32 write:
  - Stimulus: reset, `priv_level` = 1; `satp_wr_req` = 1 with `satp_mode_wdata` = 1 in cycle 0; `tlb_flush_done` pulse in cycle 3.
  - Response: `tlb_flush_req` high in cycles 1–3; `satp_wr_ack` pulse in cycle 4; `sv32` = 1 and `addr_trans_on` = 1 from cycle 5.
- Privilege gating:
  - Stimulus: Sv32 active, `priv_level` 1 → 3 in cycle t; then `mprv` = 1 with `mpp` = 0 in cycle u.
  - Response: `addr_trans_on` = 0 and `fetch_trans_on` = 0 at t+1; `addr_trans_on` = 1 at u+1 while `fetch_trans_on` stays 0.
- Simultaneous requests:
  - Stimulus: `sfence_req` and `satp_wr_req` (`satp_mode_wdata` = 0) both high in cycle 0; `tlb_flush_done` in cycle 1.
  - Response: a single flush; both acks in cycle 2; `sv32` = 0 in cycle 3.
- SFENCE only:
  - Stimulus: Sv32 active; `sfence_req` high.
  - Response: flush runs, `sfence_ack` pulses, `sv32` stays 1 throughout, `satp_wr_ack` never asserts.
- Reset mid-flush:
  - Stimulus: `RST` asserted in the second FLUSH cycle.
  - Response: next cycle is RUN, `tlb_flush_req` = 0, `sv32` = 0, no ack pulse.
- Timeout:
  - Stimulus: macro defined, `FLUSH_TIMEOUT` = 4, `tlb_flush_done` held at 0.
  - Response: APPLY after 4 FLUSH cycles; ack pulses; `flush_timeout` = 1 and sticky.
